// File: rtl/complement2_rr_sched.sv
// Round-robin front end for a shared 48-bit negation unit. The unit is configurable per transaction to 6/8/9/10/25/48-bit width.
// Results leave through a single registered stage that carries a requester tag, an overflow flag and an error flag.
module complement2_rr_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*48-1:0]  req_data,
  input  logic [N_REQ*3-1:0]   req_mode,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [47:0]          out_data,
  output logic [ID_W-1:0]      out_id,
  output logic [2:0]           out_mode,
  output logic                 out_ovf,
  output logic                 out_err
);

  logic [47:0]     data_arr [N_REQ];
  logic [2:0]      mode_arr [N_REQ];
  logic [ID_W-1:0] rr_ptr_reg;
  logic            out_valid_reg;
  logic [47:0]     out_data_reg;
  logic [ID_W-1:0] out_id_reg;
  logic [2:0]      out_mode_reg;
  logic            out_ovf_reg;
  logic            out_err_reg;

  logic            free;
  logic            grant;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;
  logic [ID_W-1:0] rr_ptr_next;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[48*gi +: 48];
      assign mode_arr[gi] = req_mode[3*gi +: 3];
    end
  endgenerate

  assign free = ~out_valid_reg | out_ready;

  // Search from rr_ptr upward, wrapping at N_REQ (which need not be a power of two).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int o = 0; o < N_REQ; o++) begin
      scan_sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(o);
      if (scan_sum >= (ID_W+1)'(N_REQ))
        scan_sum = scan_sum - (ID_W+1)'(N_REQ);
      scan_idx = scan_sum[ID_W-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign grant = grant_found & free & ~rst;

  always_comb begin
    req_ready = '0;
    if (grant)
      req_ready[grant_idx] = 1'b1;
  end

  assign rr_ptr_next = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);

  // Shared negation datapath, configured by the granted request's mode.
  logic [47:0] sel_data;
  logic [2:0]  sel_mode;
  logic [47:0] width_mask;
  logic [47:0] top_bit;
  logic        mode_err;
  logic [47:0] operand;
  logic [47:0] ones_comp;
  logic [47:0] negated;
  logic        ovf;

  assign sel_data = data_arr[grant_idx];
  assign sel_mode = mode_arr[grant_idx];

  always_comb begin
    width_mask = '0;
    top_bit    = '0;
    mode_err   = 1'b0;
    case (sel_mode)
      3'd0: begin width_mask = 48'h0000_0000_003F; top_bit = 48'h0000_0000_0020; end
      3'd1: begin width_mask = 48'h0000_0000_00FF; top_bit = 48'h0000_0000_0080; end
      3'd2: begin width_mask = 48'h0000_0000_01FF; top_bit = 48'h0000_0000_0100; end
      3'd3: begin width_mask = 48'h0000_0000_03FF; top_bit = 48'h0000_0000_0200; end
      3'd4: begin width_mask = 48'h0000_01FF_FFFF; top_bit = 48'h0000_0100_0000; end
      3'd5: begin width_mask = 48'hFFFF_FFFF_FFFF; top_bit = 48'h8000_0000_0000; end
      default: mode_err = 1'b1;
    endcase
  end

  // Illegal modes zero the mask, so the operand and the result collapse to 0.
  assign operand   = sel_data & width_mask;
  assign ones_comp = ~operand;
  assign negated   = (ones_comp + 48'd1) & width_mask;
  assign ovf       = (operand == top_bit) & ~mode_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
      out_mode_reg  <= '0;
      out_ovf_reg   <= 1'b0;
      out_err_reg   <= 1'b0;
    end else if (grant) begin
      rr_ptr_reg    <= rr_ptr_next;
      out_valid_reg <= 1'b1;
      out_data_reg  <= negated;
      out_id_reg    <= grant_idx;
      out_mode_reg  <= sel_mode;
      out_ovf_reg   <= ovf;
      out_err_reg   <= mode_err;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_id    = out_id_reg;
  assign out_mode  = out_mode_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_err   = out_err_reg;

endmodule

// File: tb/tb_complement2_rr_sched.sv
// Scoreboard bench for complement2_rr_sched. Expected results are queued at grant time from a bench-side model.
// They are then compared when the output stage hands each result off downstream.
module tb_complement2_rr_sched;

  localparam int N = 4;

  typedef struct {
    logic [47:0] data;
    logic [1:0]  id;
    logic [2:0]  mode;
    logic        ovf;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*48-1:0] req_data;
  logic [N*3-1:0]  req_mode;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic          out_ready;
  logic [47:0]   out_data;
  logic [1:0]    out_id;
  logic [2:0]    out_mode;
  logic          out_ovf;
  logic          out_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  logic m_valid = 1'b0;
  int   m_ptr = 0;

  complement2_rr_sched #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_mode(req_mode), .req_ready(req_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_mode(out_mode), .out_ovf(out_ovf), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Negation as 2^k - x, reduced mod 2^k.
  function automatic exp_t model(input logic [47:0] d, input logic [2:0] m, input int id);
    exp_t e;
    int k;
    logic [48:0] full, x, r;
    case (m)
      3'd0: k = 6;
      3'd1: k = 8;
      3'd2: k = 9;
      3'd3: k = 10;
      3'd4: k = 25;
      3'd5: k = 48;
      default: k = 0;
    endcase
    e.id   = id[1:0];
    e.mode = m;
    e.err  = (k == 0);
    e.data = '0;
    e.ovf  = 1'b0;
    if (k != 0) begin
      full   = 49'h1 << k;
      x      = {1'b0, d} & (full - 49'h1);
      r      = (full - x) & (full - 49'h1);
      e.data = r[47:0];
      e.ovf  = (x == (full >> 1));
    end
    return e;
  endfunction

  task automatic set_req(input int i, input logic [47:0] d, input logic [2:0] m);
    req_data[48*i +: 48] = d;
    req_mode[3*i +: 3]   = m;
  endtask

  // Advances one cycle; the model tracks grants and the scoreboard checks each output transfer.
  task automatic tick();
    int g;
    int idx;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_ptr   = 0;
    end else begin
      if (m_valid && out_ready) begin
        n_cmp++;
        e = exp_q.pop_front();
        $display("txn id=%0d mode=%0d data=%h ovf=%b err=%b", out_id, out_mode, out_data, out_ovf, out_err);
        if (out_valid !== 1'b1 || out_data !== e.data || out_id !== e.id ||
            out_mode !== e.mode || out_ovf !== e.ovf || out_err !== e.err)
        begin
          n_bad++;
          $display("FAIL scoreboard: got v=%b d=%h id=%0d m=%0d o=%b e=%b, want d=%h id=%0d m=%0d o=%b e=%b",
                   out_valid, out_data, out_id, out_mode, out_ovf, out_err,
                   e.data, e.id, e.mode, e.ovf, e.err);
        end
      end
      g = -1;
      if (!m_valid || out_ready) begin
        for (int o = 0; o < N; o++) begin
          idx = (m_ptr + o) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) begin
        exp_q.push_back(model(req_data[48*g +: 48], req_mode[3*g +: 3], g));
        m_ptr   = (g + 1) % N;
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; out_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b0 || out_data !== 48'h0 || out_id !== 2'd0) begin
      n_bad++;
      $display("FAIL reset: got rdy=%b v=%b d=%h id=%0d, want 0000 0 0 0", req_ready, out_valid, out_data, out_id);
    end
    rst = 1'b0; req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 48'h5, 3'd1);
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    n_cmp++;
    if (out_data !== 48'h0000_0000_00FB || out_id !== 2'd0 || out_ovf !== 1'b0) begin
      n_bad++; $display("FAIL single_out: got d=%h id=%0d o=%b want 00000000fb 0 0", out_data, out_id, out_ovf);
    end
    tick();
  endtask

  task automatic test_mode_sweep();
    req_valid = 4'b0100;
    for (int m = 0; m < 6; m++) begin
      set_req(2, 48'hFFFF_FFFF_FFFF, 3'(m));
      tick();
      n_cmp++;
      if (out_data !== 48'h1 || out_id !== 2'd2) begin
        n_bad++; $display("FAIL sweep_mode%0d: got d=%h id=%0d want 1 2", m, out_data, out_id);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_ovf_illegal();
    set_req(1, 48'h100_0000, 3'd4);
    req_valid = 4'b0010;
    tick();
    n_cmp++;
    if (out_data !== 48'h100_0000 || out_ovf !== 1'b1 || out_err !== 1'b0) begin
      n_bad++; $display("FAIL most_negative: got d=%h o=%b e=%b want 1000000 1 0", out_data, out_ovf, out_err);
    end
    set_req(1, 48'h1234_5678_9ABC, 3'd7);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL illegal_ready: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    n_cmp++;
    if (out_data !== 48'h0 || out_err !== 1'b1 || out_ovf !== 1'b0 || out_mode !== 3'd7) begin
      n_bad++; $display("FAIL illegal_out: got d=%h e=%b o=%b m=%0d want 0 1 0 7", out_data, out_err, out_ovf, out_mode);
    end
    tick();
  endtask

  task automatic test_rotation();
    req_valid = 4'b1000;
    tick();
    for (int i = 0; i < N; i++)
      set_req(i, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      set_req(i % N, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
      n_cmp++;
      if (out_valid !== 1'b1 || out_id !== 2'(i % N)) begin
        n_bad++; $display("FAIL rotation_%0d: got v=%b id=%0d want 1 %0d", i, out_valid, out_id, i % N);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t front;
    int next_g;
    // The rotation just finished on requester 3, so a result from 3 is pending and requester 0 is next.
    out_ready = 1'b0;
    front = exp_q[0];
    next_g = m_ptr;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== front.data || out_id !== front.id) begin
        n_bad++; $display("FAIL stall_%0d: got rdy=%b v=%b d=%h id=%0d want 0000 1 %h %0d",
                          c, req_ready, out_valid, out_data, out_id, front.data, front.id);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'(1 << next_g)) begin
      n_bad++; $display("FAIL release_grant: got %b want %b", req_ready, 4'(1 << next_g));
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_id !== 2'(next_g)) begin
      n_bad++; $display("FAIL release_out: got v=%b id=%0d want 1 %0d", out_valid, out_id, next_g);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1111;
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 48'h0 || out_id !== 2'd0 || out_mode !== 3'd0 ||
        out_ovf !== 1'b0 || out_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid: got v=%b d=%h id=%0d m=%0d o=%b e=%b want all 0",
                        out_valid, out_data, out_id, out_mode, out_ovf, out_err);
    end
    rst = 1'b0;
    req_valid = 4'b0110;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL reset_first_grant: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    n_cmp++;
    if (out_id !== 2'd1 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL reset_first_out: got v=%b id=%0d want 1 1", out_valid, out_id);
    end
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_mode = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_mode_sweep();
    test_ovf_illegal();
    test_rotation();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
